// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one binary<->Gray converter
// between two valid/ready requesters, single-entry output.
module gray_conv_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_mode,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] cap_data;
  logic             cap_mode;
  logic             cap_src;
  logic [WIDTH-1:0] conv;
  logic             gnt0;
  logic             gnt1;
  logic             idle;

  // On a tie, favour whoever was not served last.
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);
  assign gnt0 = req0_valid & ~gnt1;

  assign idle       = rst_n & (state == IDLE);
  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;
  assign busy       = (state != IDLE);

  always_comb begin
    conv = '0;
    conv[WIDTH-1] = cap_data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (cap_mode)
        conv[i] = conv[i+1] ^ cap_data[i];
      else
        conv[i] = cap_data[i+1] ^ cap_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cap_data   <= '0;
      cap_mode   <= 1'b0;
      cap_src    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            cap_data   <= gnt1 ? req1_data : req0_data;
            cap_mode   <= gnt1 ? req1_mode : req0_mode;
            cap_src    <= gnt1;
            last_grant <= gnt1;
            state      <= CONV;
          end
        end
        CONV: begin
          out_data  <= conv;
          out_src   <= cap_src;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gray_conv_sched.md
# gray_conv_sched

Scheduler that shares a single binary↔Gray code conversion datapath between two requesters. Each requester presents a code word plus a direction bit through a valid/ready handshake. The block arbitrates round-robin, runs one conversion, and holds the result at a single output port with backpressure until it is consumed. It sits between the lab's stimulus/control logic and the combinational converter, so one converter instance serves both users.

## Interface
- WIDTH, 4, code word width in bits (≥2)
- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 word
- req0_mode  input  1  0 = binary→Gray, 1 = Gray→binary
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid / req1_data / req1_mode / req1_ready  same as requester 0, for requester 1
- out_valid  output  1  result available
- out_data  output  WIDTH  converted word
- out_src  output  1  requester index that produced out_data
- out_ready  input  1  consumer takes result this cycle
- busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, CONV, HOLD.
- IDLE: if neither valid → stay. Else grant one requester and capture its data, mode, and index into internal registers → CONV.
- Grant rule: only one valid → grant it. Both valid → grant the requester not granted last. last_grant resets to 1, so req0 wins the first tie.
- reqN_ready is combinational: high only in IDLE, for the granted requester, and only when its valid is high. The transfer occurs when valid & ready are both high at the clock edge. The non-granted requester sees ready = 0 and must hold its valid and data.
- CONV: compute the result from captured registers and register it into out_data/out_src → HOLD.
  - Binary→Gray: g[i] = b[i] ^ b[i+1]; g[MSB] = b[MSB].
  - Gray→binary: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i] (prefix XOR from the MSB).
- HOLD: out_valid = 1, with out_data/out_src stable. When out_ready = 1 at the edge → IDLE, out_valid drops next cycle. When out_ready = 0 → stay, with all outputs held.
- Requester inputs changing during CONV/HOLD have no effect. Only the captured copy is used.
- No overflow or underflow: output is single-entry, and the input is stalled while the result is occupied.

## Timing
- Reset (rst_n = 0 at edge), from any state including mid-conversion:
  - state = IDLE; out_valid = 0, out_data = 0, out_src = 0, busy = 0; req0_ready = req1_ready = 0 during the reset cycle; last_grant = 1.
  - An in-flight word is discarded, and no output is produced for it.
- Accept at edge E0 → CONV in the following cycle → out_valid high from the cycle after edge E0+1. Latency is 2 cycles from accept to out_valid.
- Minimum spacing: 3 cycles per transaction (IDLE, CONV, HOLD with out_ready = 1).
- out_ready is ignored outside HOLD.
- A requester holding valid continuously while the other is idle is served every 3 cycles with out_ready = 1.

## Test plan
- Reset: assert rst_n = 0 for 2 cycles with both valids high → out_valid = 0, out_data = 0, both readys 0, busy = 0.
- Binary→Gray: req0 valid, data 4'b1011, mode 0, out_ready = 1 → req0_ready pulses 1 cycle; out_valid 2 cycles later with out_data = 4'b1110, out_src = 0. Also check 4'b0110 → 4'b0101.
- Gray→binary: req1 data 4'b1110, mode 1 → out_data = 4'b1011, out_src = 1. Also check 4'b1000 → 4'b1111.
- Round-robin tie: both valid continuously (req0 0001 mode 0, req1 0011 mode 1), out_ready = 1 → grants alternate 0,1,0,1. Outputs alternate 0001 (src 0) and 0010 (src 1).
- Backpressure: out_ready = 0 for 5 cycles in HOLD → out_valid, out_data, and out_src stable; both readys 0 with valids high. Raise out_ready → out_valid drops next cycle and the next grant follows.
- Mid-operation reset: assert rst_n = 0 during CONV → outputs clear next cycle. The captured word never appears on out_data, and req0 wins the first tie after release.
